rva_core_wbu_ret_buf_mp: RTL and testbench



---
 rtl/rva_core_wbu_ret_buf_mp.sv | 253 +++++++++++++++++++++++++
 tb/tb_rva_core_wbu_ret_buf_mp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rva_core_wbu_ret_buf_mp.sv
// rva_core_wbu_ret_buf_mp: multi-port, key-associative retire buffer for the
// write-back unit. NUM_WR producers write (key, data) pairs out of order.
// NUM_RD consumers look entries up by key and retire them on handshake.
// Duplicate keys merge in place. When several read ports hit the same key in
// one cycle, the lowest-index port wins.
// Optional feature: define RVA_CORE_RET_BUF_BYPASS_EN to enable the
// same-cycle write-to-read bypass of accepted allocating writes.
module rva_core_wbu_ret_buf_mp #(
    parameter int unsigned BUF_DEPTH  = 16,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned KEY_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter type KEY_TYPE  = logic [KEY_WIDTH-1:0],
    parameter type DATA_TYPE = logic [DATA_WIDTH-1:0],
    localparam int unsigned CNT_WIDTH = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic [NUM_WR-1:0]                     wvalid_i,
    output logic [NUM_WR-1:0]                     wready_o,
    input  logic [NUM_WR-1:0][KEY_WIDTH-1:0]      wkey_i,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [NUM_RD-1:0][KEY_WIDTH-1:0]      rkey_i,
    output logic [NUM_RD-1:0]                     rvalid_o,
    input  logic [NUM_RD-1:0]                     rready_i,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rdata_o,
    output logic [CNT_WIDTH-1:0]                  count_o,
    output logic                                  full_o,
    output logic                                  empty_o
);

    KEY_TYPE                          key_q  [BUF_DEPTH];
    DATA_TYPE                         data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]             vld_q, vld_d;
    logic [CNT_WIDTH-1:0]             count_q, count_d;

    logic [NUM_RD-1:0][BUF_DEPTH-1:0] rhit_oh;
    logic [NUM_RD-1:0]                rs_hit;
    logic [NUM_WR-1:0][BUF_DEPTH-1:0] wm_oh;
    logic [NUM_WR-1:0]                wmerge;
    logic [NUM_WR-1:0][CNT_WIDTH-1:0] wrank;
    logic [NUM_WR-1:0]                wacc_new;
    logic [CNT_WIDTH-1:0]             free_cnt;
    logic [NUM_RD-1:0][NUM_WR-1:0]    byp_oh;
    logic [NUM_RD-1:0]                rhit_raw;
    logic [BUF_DEPTH-1:0]             ret_vec;
    logic [BUF_DEPTH-1:0]             merge_vec;
    logic [NUM_WR-1:0]                consumed;
    logic [BUF_DEPTH-1:0]             alloc_vec;
    logic [NUM_WR-1:0][BUF_DEPTH-1:0] wa_oh;
    logic [BUF_DEPTH-1:0]             ent_dwe, ent_kwe;
    KEY_TYPE                          ent_key [BUF_DEPTH];
    DATA_TYPE                         ent_dat [BUF_DEPTH];
    logic                             dup_wr;

    function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [BUF_DEPTH-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            n = n + CNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

    // Storage lookup: one-hot hit vector per read port (keys are unique).
    always_comb begin
        rhit_oh = '0;
        rs_hit  = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
                rhit_oh[k][e] = vld_q[e] && (key_q[e] == rkey_i[k]);
            end
            rs_hit[k] = |rhit_oh[k];
        end
    end

    // Write classification: merge detection, allocation rank and wready.
    always_comb begin
        logic [CNT_WIDTH-1:0] rank;
        wm_oh    = '0;
        wmerge   = '0;
        wrank    = '0;
        wready_o = '0;
        wacc_new = '0;
        rank     = '0;
        free_cnt = popcnt(~vld_q);
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
                wm_oh[j][e] = vld_q[e] && (key_q[e] == wkey_i[j]);
            end
            wmerge[j]   = |wm_oh[j];
            wrank[j]    = rank;
            wready_o[j] = wmerge[j] || (free_cnt > rank);
            wacc_new[j] = wvalid_i[j] && wready_o[j] && !wmerge[j];
            if (wvalid_i[j] && !wmerge[j]) begin
                rank = rank + CNT_WIDTH'(1);
            end
        end
    end

    // Bypass match of read ports against accepted allocating writes.
    always_comb begin
        byp_oh = '0;
`ifdef RVA_CORE_RET_BUF_BYPASS_EN
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                byp_oh[k][j] = !rs_hit[k] && wacc_new[j] && (wkey_i[j] == rkey_i[k]);
            end
        end
`endif
    end

    // Read presentation with lowest-index-wins arbitration on equal keys.
    always_comb begin
        rhit_raw = '0;
        rvalid_o = '0;
        rdata_o  = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rhit_raw[k] = rs_hit[k] || (|byp_oh[k]);
            for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
                if (rhit_oh[k][e]) begin
                    rdata_o[k] = rdata_o[k] | data_q[e];
                end
            end
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (byp_oh[k][j]) begin
                    rdata_o[k] = rdata_o[k] | wdata_i[j];
                end
            end
        end
        // Unique storage keys (and unique write keys) make equal lookup keys
        // equivalent to hitting the same entry or the same bypassed write.
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rvalid_o[k] = rhit_raw[k];
            for (int unsigned m = 0; m < k; m++) begin
                if (rhit_raw[m] && (rkey_i[m] == rkey_i[k])) begin
                    rvalid_o[k] = 1'b0;
                end
            end
        end
    end

    // Retire, merge and bypass-consume bookkeeping from completed handshakes.
    always_comb begin
        ret_vec   = '0;
        merge_vec = '0;
        consumed  = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (rvalid_o[k] && rready_i[k]) begin
                ret_vec  = ret_vec | rhit_oh[k];
                consumed = consumed | byp_oh[k];
            end
        end
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wvalid_i[j]) begin
                merge_vec = merge_vec | wm_oh[j];
            end
        end
    end

    // Allocation: the port of rank r takes the r-th free entry in index order.
    always_comb begin
        logic [CNT_WIDTH-1:0] fr;
        alloc_vec = '0;
        wa_oh     = '0;
        fr        = '0;
        for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
            if (!vld_q[e]) begin
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (wacc_new[j] && !consumed[j] && (wrank[j] == fr)) begin
                        alloc_vec[e] = 1'b1;
                        wa_oh[j][e]  = 1'b1;
                    end
                end
                fr = fr + CNT_WIDTH'(1);
            end
        end
    end

    // Per-entry key/data write enables and next valid/occupancy state.
    always_comb begin
        ent_dwe = '0;
        ent_kwe = '0;
        for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
            ent_key[e] = '0;
            ent_dat[e] = '0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wa_oh[j][e]) begin
                    ent_kwe[e] = 1'b1;
                    ent_dwe[e] = 1'b1;
                    ent_key[e] = wkey_i[j];
                    ent_dat[e] = wdata_i[j];
                end else if (wvalid_i[j] && wm_oh[j][e]) begin
                    ent_dwe[e] = 1'b1;
                    ent_dat[e] = wdata_i[j];
                end
            end
        end
        // A merge on an entry being retired keeps it valid with the new data.
        vld_d   = (vld_q & ~(ret_vec & ~merge_vec)) | alloc_vec;
        count_d = count_q + popcnt(alloc_vec) - popcnt(ret_vec & ~merge_vec);
    end

    // Duplicate-key detection across write ports in one cycle.
    always_comb begin
        dup_wr = 1'b0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            for (int unsigned m = j + 1; m < NUM_WR; m++) begin
                if (wvalid_i[j] && wvalid_i[m] && (wkey_i[j] == wkey_i[m])) begin
                    dup_wr = 1'b1;
                end
            end
        end
    end

    // Valid bits and occupancy: reset dominates flush, flush dominates traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // Key/data storage: write-enabled only, no reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
            if (ent_kwe[e]) begin
                key_q[e] <= ent_key[e];
            end
            if (ent_dwe[e]) begin
                data_q[e] <= ent_dat[e];
            end
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_WIDTH'(BUF_DEPTH));
    assign empty_o = (count_q == '0);

    a_count_popcnt: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q == popcnt(vld_q));
    a_no_dup_wkey: assert property (@(posedge clk_i) disable iff (rst_i)
        !dup_wr);

endmodule

// File: tb/tb_rva_core_wbu_ret_buf_mp.sv
// Self-checking bench for rva_core_wbu_ret_buf_mp: directed scenarios plus
// randomized traffic against a key-to-data associative reference model.
module tb_rva_core_wbu_ret_buf_mp;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NW    = 2;
    localparam int unsigned NR    = 2;
    localparam int unsigned CW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic [NW-1:0]       wvalid = '0;
    logic [NW-1:0]       wready;
    logic [NW-1:0][15:0] wkey = '0;
    logic [NW-1:0][31:0] wdata = '0;
    logic [NR-1:0][15:0] rkey = '0;
    logic [NR-1:0]       rvalid;
    logic [NR-1:0]       rready = '0;
    logic [NR-1:0][31:0] rdata;
    logic [CW-1:0]       count;
    logic                full, empty;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the set of stored (key -> data) pairs.
    logic [31:0] mem [logic [15:0]];

    rva_core_wbu_ret_buf_mp #(
        .BUF_DEPTH (16),
        .NUM_WR    (2),
        .NUM_RD    (2),
        .KEY_WIDTH (16),
        .DATA_WIDTH(32)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .wvalid_i(wvalid),
        .wready_o(wready),
        .wkey_i  (wkey),
        .wdata_i (wdata),
        .rkey_i  (rkey),
        .rvalid_o(rvalid),
        .rready_i(rready),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: compare outputs at the negedge against the model, then
    // advance the model with the handshakes of this cycle.
    task automatic step(input bit do_check);
        int            free_n;
        int            rank;
        int            src [NR];
        logic [NW-1:0] merge, exp_wr, acc_new, consumed;
        logic [NR-1:0] hit, exp_rv, from_store;
        logic [31:0]   exp_rd [NR];
        logic [15:0]   ret_keys [$];
        @(negedge clk);
        free_n = DEPTH - mem.num();
        rank   = 0;
        for (int j = 0; j < NW; j++) begin
            merge[j]   = mem.exists(wkey[j]);
            exp_wr[j]  = merge[j] || (free_n > rank);
            acc_new[j] = wvalid[j] && exp_wr[j] && !merge[j];
            if (wvalid[j] && !merge[j]) rank++;
        end
        for (int k = 0; k < NR; k++) begin
            hit[k] = 1'b0;
            from_store[k] = 1'b0;
            exp_rd[k] = '0;
            src[k] = 0;
            if (mem.exists(rkey[k])) begin
                hit[k] = 1'b1;
                from_store[k] = 1'b1;
                exp_rd[k] = mem[rkey[k]];
            end
`ifdef RVA_CORE_RET_BUF_BYPASS_EN
            else begin
                for (int j = 0; j < NW; j++) begin
                    if (acc_new[j] && wkey[j] == rkey[k]) begin
                        hit[k] = 1'b1;
                        exp_rd[k] = wdata[j];
                        src[k] = j;
                    end
                end
            end
`endif
            exp_rv[k] = hit[k];
            for (int m = 0; m < k; m++) begin
                if (hit[m] && rkey[m] == rkey[k]) exp_rv[k] = 1'b0;
            end
        end
        if (do_check) begin
            chk("count", count, mem.num());
            chk("full", full, mem.num() == DEPTH);
            chk("empty", empty, mem.num() == 0);
            chk("wready", wready, exp_wr);
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("rvalid%0d", k), rvalid[k], exp_rv[k]);
                if (exp_rv[k] || !hit[k]) chk($sformatf("rdata%0d", k), rdata[k], exp_rd[k]);
            end
        end
        consumed = '0;
        if (rst || flush) begin
            mem.delete();
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (exp_rv[k] && rready[k]) begin
                    if (from_store[k]) ret_keys.push_back(rkey[k]);
                    else consumed[src[k]] = 1'b1;
                end
            end
            foreach (ret_keys[i]) mem.delete(ret_keys[i]);
            for (int j = 0; j < NW; j++) begin
                if (wvalid[j] && exp_wr[j] && !consumed[j]) mem[wkey[j]] = wdata[j];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush  = 1'b0;
        wvalid = '0;
        rready = '0;
    endtask

    initial begin
        // Reset, then idle.
        step(0);
        step(1);
        rst = 1'b0;
        rkey[0] = 16'h0005;
        rkey[1] = 16'h1234;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wready", wready, 2'b11);
        chk("rst_rvalid", rvalid, 2'b00);
        step(1);

        // Single write, held lookup, then retire.
        wvalid = 2'b01; wkey[0] = 16'h0005; wdata[0] = 32'hAAAA;
        step(1);
        idle_inputs();
        rkey[0] = 16'h0005; rkey[1] = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("hold_rvalid", rvalid[0], 1);
            chk("hold_rdata", rdata[0], 32'hAAAA);
            chk("hold_count", count, 1);
            step(1);
        end
        rready = 2'b01;
        step(1);
        idle_inputs();
        #2;
        chk("retire_count", count, 0);

        // Fill 15 entries, then offer two new keys.
        for (int i = 1; i <= 15; i++) begin
            wvalid = 2'b01;
            wkey[0] = 16'(i);
            wdata[0] = (i == 7) ? 32'h1111 : (32'hD000_0000 | 32'(i));
            step(1);
        end
        wvalid = 2'b11; wkey[0] = 16'h0020; wkey[1] = 16'h0021;
        #2;
        chk("fill_wready_01", wready, 2'b01);
        chk("fill_count15", count, 15);
        step(1);
        wkey[0] = 16'h0022;
        #2;
        chk("full_wready_00", wready, 2'b00);
        chk("full_count", count, 16);
        chk("full_flag", full, 1);
        step(1);

        // Merge while full.
        wvalid = 2'b01; wkey[0] = 16'h0007; wdata[0] = 32'h2222;
        #2;
        chk("merge_wready", wready[0], 1);
        step(1);
        idle_inputs();
        rkey[0] = 16'h0007;
        #2;
        chk("merge_count", count, 16);
        chk("merge_rvalid", rvalid[0], 1);
        chk("merge_rdata", rdata[0], 32'h2222);
        step(1);

        // Same-key read on both ports.
        rkey[0] = 16'h0003; rkey[1] = 16'h0003; rready = 2'b11;
        #2;
        chk("arb_rvalid", rvalid, 2'b01);
        chk("arb_rdata", rdata[0], 32'hD000_0003);
        step(1);
        idle_inputs();
        #2;
        chk("arb_count", count, 15);

        // Flush with a simultaneous write.
        flush = 1'b1; wvalid = 2'b01; wkey[0] = 16'h0009; wdata[0] = 32'h9999;
        step(1);
        idle_inputs();
        rkey[0] = 16'h0009; rkey[1] = 16'h0009;
        #2;
        chk("flush_count", count, 0);
        chk("flush_rvalid", rvalid, 2'b00);
        step(1);

        // Same-cycle write and read of one key.
        wvalid = 2'b01; wkey[0] = 16'h000A; wdata[0] = 32'hBEEF;
        rkey[0] = 16'h000A; rkey[1] = 16'hFFFF; rready = 2'b01;
        #2;
`ifdef RVA_CORE_RET_BUF_BYPASS_EN
        chk("byp_rvalid", rvalid[0], 1);
        chk("byp_rdata", rdata[0], 32'hBEEF);
`else
        chk("nobyp_rvalid", rvalid[0], 0);
`endif
        step(1);
        idle_inputs();
        #2;
`ifdef RVA_CORE_RET_BUF_BYPASS_EN
        chk("byp_count", count, 0);
`else
        chk("nobyp_count", count, 1);
        chk("nobyp_late_rvalid", rvalid[0], 1);
`endif
        step(1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 499) == 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int j = 0; j < NW; j++) begin
                wvalid[j] = ($urandom_range(0, 2) == 0);
                wkey[j]   = 16'($urandom_range(0, 23));
                wdata[j]  = $urandom;
            end
            if (wkey[1] == wkey[0]) wkey[1] = wkey[0] ^ 16'h0020;
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 3) == 0) rkey[k] = wkey[$urandom_range(0, 1)];
                else rkey[k] = 16'($urandom_range(0, 23));
                rready[k] = $urandom_range(0, 1) == 1;
            end
            step(1);
        end
        rst = 1'b0;
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
